// File: rtl/seq_restoring_divider_16x8.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock, MSB first.
// Ports: clk, rst (sync, active-high), in_valid/in_ready + dividend/divisor in,
//        out_valid/out_ready + quotient/remainder/div_by_zero out.
module seq_restoring_divider_16x8 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2 * N);

    // ZERO is a one-cycle hop that gives divide-by-zero its one-clock latency.
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ZERO,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N:0]     rem_q, rem_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [2*N-1:0] quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     shifted;
    logic           q_bit;
    logic [N:0]     rem_next;
    logic [2*N-1:0] dvd_next;

    // The dividend register shifts out its MSB each step; quotient bits
    // enter at the LSB, so after 2N steps it holds the quotient.
    always_comb begin
        shifted  = {rem_q[N-1:0], dvd_q[2*N-1]};
        q_bit    = (shifted >= {1'b0, dvs_q});
        rem_next = q_bit ? (shifted - {1'b0, dvs_q}) : shifted;
        dvd_next = {dvd_q[2*N-2:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (divisor == '0) ? ZERO : BUSY;
                end
            end
            BUSY: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(2 * N - 1)) begin
                    state_d     = DONE;
                    quotient_d  = dvd_next;
                    remainder_d = rem_next[N-1:0];
                    dbz_d       = 1'b0;
                end
            end
            ZERO: begin
                state_d     = DONE;
                quotient_d  = '1;
                remainder_d = dvd_q[N-1:0];
                dbz_d       = 1'b1;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
